// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: gates camera pixels into the threshold stage, builds
// delay-matched frame-buffer write addresses and shares the BRAM port with a reader.
module frame_capture_ctrl #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 240,
    parameter int TH_LAT   = 1,
    parameter int RD_LAT   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        continuous_in,
    input  logic        abort_in,
    input  logic [8:0]  hcount_in,
    input  logic [7:0]  vcount_in,
    input  logic        pix_valid_in,
    output logic        thr_valid_out,
    input  logic        rd_req_in,
    input  logic [16:0] rd_addr_in,
    output logic        rd_grant_out,
    output logic        rd_valid_out,
    output logic [16:0] mem_addr_out,
    output logic        mem_we_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        err_out,
    output logic [7:0]  frame_cnt_out,
    output logic [1:0]  state_dbg_out
);

    // Handshake: rd_req_in is a level held by the reader until rd_grant_out is
    // seen high in the same cycle; rd_valid_out follows each grant by RD_LAT cycles.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [8:0] H_LAST = 9'(H_ACTIVE - 1);
    localparam logic [7:0] V_LAST = 8'(V_ACTIVE - 1);

    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [TH_LAT-1:0] wr_vld_q, wr_vld_d;
    logic [16:0]       wr_addr_q [TH_LAT];
    logic [16:0]       wr_addr_d [TH_LAT];
    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;

    logic        in_range, frame_start, frame_end, fwd;
    logic [16:0] pix_addr;

    always_comb begin
        in_range    = pix_valid_in && (hcount_in <= H_LAST) && (vcount_in <= V_LAST);
        frame_start = in_range && (hcount_in == 9'd0) && (vcount_in == 8'd0);
        frame_end   = in_range && (hcount_in == H_LAST) && (vcount_in == V_LAST);
        pix_addr    = 17'(vcount_in) * 17'(H_ACTIVE) + 17'(hcount_in);
    end

    // An aborting cycle forwards nothing; earlier pixels drain through the pipe.
    always_comb begin
        fwd = 1'b0;
        if (!abort_in) begin
            case (state_q)
                S_ARMED:   fwd = frame_start;
                S_CAPTURE: fwd = in_range;
                default:   fwd = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        if (abort_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        state_d = S_ARMED;
                        err_d   = 1'b0;
                    end
                end
                S_ARMED: begin
                    if (frame_start) state_d = S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (frame_end)        state_d = S_DONE;
                    else if (frame_start) err_d   = 1'b1;
                end
                S_DONE: begin
                    state_d = continuous_in ? S_ARMED : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (state_q == S_DONE) frame_cnt_d = frame_cnt_q + 8'd1;
    end

    always_comb begin
        wr_vld_d[0]  = fwd;
        wr_addr_d[0] = pix_addr;
        for (int i = 1; i < TH_LAT; i++) begin
            wr_vld_d[i]  = wr_vld_q[i-1];
            wr_addr_d[i] = wr_addr_q[i-1];
        end
        rd_vld_d[0] = rd_grant_out;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            err_q       <= 1'b0;
            frame_cnt_q <= 8'd0;
            wr_vld_q    <= '0;
            rd_vld_q    <= '0;
            for (int i = 0; i < TH_LAT; i++) wr_addr_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            wr_vld_q    <= wr_vld_d;
            rd_vld_q    <= rd_vld_d;
            for (int i = 0; i < TH_LAT; i++) wr_addr_q[i] <= wr_addr_d[i];
        end
    end

    // Writes own the port; the grant is also held low while reset is asserted.
    always_comb begin
        thr_valid_out = fwd;
        mem_we_out    = wr_vld_q[TH_LAT-1];
        rd_grant_out  = rst_in && rd_req_in && !mem_we_out;
        if (mem_we_out)        mem_addr_out = wr_addr_q[TH_LAT-1];
        else if (rd_grant_out) mem_addr_out = rd_addr_in;
        else                   mem_addr_out = '0;
        rd_valid_out  = rd_vld_q[RD_LAT-1];
        busy_out      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
        done_out      = (state_q == S_DONE);
        err_out       = err_q;
        frame_cnt_out = frame_cnt_q;
        state_dbg_out = state_q;
    end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl: scenario tasks drive a cycle-level behavioural model;
// a negedge scoreboard compares every output against it each cycle.
`timescale 1ns/1ps
module tb_frame_capture_ctrl;

    localparam int H = 320;
    localparam int V = 240;
    localparam int TH_LAT = 1;
    localparam int RD_LAT = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        start_in = 1'b0, continuous_in = 1'b0, abort_in = 1'b0;
    logic [8:0]  hcount_in = '0;
    logic [7:0]  vcount_in = '0;
    logic        pix_valid_in = 1'b0;
    logic        rd_req_in = 1'b0;
    logic [16:0] rd_addr_in = '0;
    logic        thr_valid_out, rd_grant_out, rd_valid_out, mem_we_out;
    logic        busy_out, done_out, err_out;
    logic [16:0] mem_addr_out;
    logic [7:0]  frame_cnt_out;
    logic [1:0]  state_dbg_out;

    frame_capture_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .continuous_in(continuous_in), .abort_in(abort_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .pix_valid_in(pix_valid_in),
        .thr_valid_out(thr_valid_out), .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in),
        .rd_grant_out(rd_grant_out), .rd_valid_out(rd_valid_out),
        .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out),
        .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
        .frame_cnt_out(frame_cnt_out), .state_dbg_out(state_dbg_out)
    );

    always #5 clk_in = ~clk_in;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: capture phase flags, frame tally and in-flight write/read pipes.
    bit   m_armed, m_cap, m_done_now, m_err;
    int   m_frames;
    logic [17:0] exp_q[$];
    logic        rdv_q[$];
    bit   rd_pend;
    logic [16:0] rd_addr_v;
    bit   cont_v;

    // Per-cycle expectations consumed by the scoreboard.
    bit   mon_en = 0;
    logic exp_fwd, exp_we, exp_grant, exp_rdv, exp_busy, exp_done, exp_err;
    logic [16:0] exp_waddr, exp_raddr;
    logic [7:0]  exp_cnt;

    int writes_seen = 0, grants_seen = 0, done_seen = 0;
    logic [16:0] last_waddr = '0;

    task automatic model_reset();
        m_armed = 0; m_cap = 0; m_done_now = 0; m_err = 0; m_frames = 0;
        rd_pend = 0; cont_v = 0;
        exp_q.delete();
        rdv_q.delete();
        repeat (TH_LAT) exp_q.push_back(18'd0);
        repeat (RD_LAT) rdv_q.push_back(1'b0);
    endtask

    // One clock cycle: drive at posedge+1, scoreboard samples at negedge, model advances at posedge.
    task automatic step(input logic pv, input logic [8:0] h, input logic [7:0] v,
                        input logic st, input logic ab);
        bit in_r, fs, last;
        logic [17:0] head;
        logic dummy_b;
        pix_valid_in = pv; hcount_in = h; vcount_in = v;
        start_in = st; abort_in = ab; continuous_in = cont_v;
        rd_req_in = rd_pend; rd_addr_in = rd_addr_v;
        in_r = pv && (int'(h) < H) && (int'(v) < V);
        fs   = in_r && h == 0 && v == 0;
        last = in_r && int'(h) == H - 1 && int'(v) == V - 1;
        exp_fwd   = !ab && ((m_armed && fs) || (m_cap && in_r));
        head      = exp_q[0];
        exp_we    = head[17];
        exp_waddr = head[16:0];
        exp_grant = rd_pend && !exp_we;
        exp_raddr = rd_addr_v;
        exp_rdv   = rdv_q[0];
        exp_busy  = m_armed || m_cap;
        exp_done  = m_done_now;
        exp_err   = m_err;
        exp_cnt   = 8'(m_frames % 256);
        @(negedge clk_in);
        @(posedge clk_in);
        head = exp_q.pop_front();
        exp_q.push_back({exp_fwd, 17'(int'(v) * H + int'(h))});
        dummy_b = rdv_q.pop_front();
        rdv_q.push_back(exp_grant);
        if (exp_grant) rd_pend = 0;
        if (m_done_now) m_frames++;
        if (ab) begin
            m_armed = 0; m_cap = 0; m_done_now = 0;
        end else if (m_done_now) begin
            m_done_now = 0; m_armed = cont_v;
        end else if (m_armed) begin
            if (fs) begin m_armed = 0; m_cap = 1; end
        end else if (m_cap) begin
            if (exp_fwd && last) begin m_cap = 0; m_done_now = 1; end
            else if (fs) m_err = 1;
        end else if (st) begin
            m_armed = 1; m_err = 0;
        end
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk_in) begin
        if (mon_en) begin
            tests_run++;
            if (thr_valid_out !== exp_fwd) begin tests_failed++;
                $display("FAIL thr_valid t=%0t got %b exp %b", $time, thr_valid_out, exp_fwd); end
            tests_run++;
            if (mem_we_out !== exp_we) begin tests_failed++;
                $display("FAIL mem_we t=%0t got %b exp %b", $time, mem_we_out, exp_we); end
            if (exp_we) begin
                tests_run++;
                if (mem_addr_out !== exp_waddr) begin tests_failed++;
                    $display("FAIL wr_addr t=%0t got %0d exp %0d", $time, mem_addr_out, exp_waddr); end
            end
            tests_run++;
            if (rd_grant_out !== exp_grant) begin tests_failed++;
                $display("FAIL rd_grant t=%0t got %b exp %b", $time, rd_grant_out, exp_grant); end
            if (exp_grant) begin
                tests_run++;
                if (mem_addr_out !== exp_raddr) begin tests_failed++;
                    $display("FAIL rd_addr t=%0t got %0d exp %0d", $time, mem_addr_out, exp_raddr); end
            end
            tests_run++;
            if (rd_valid_out !== exp_rdv) begin tests_failed++;
                $display("FAIL rd_valid t=%0t got %b exp %b", $time, rd_valid_out, exp_rdv); end
            tests_run++;
            if ({busy_out, done_out, err_out, frame_cnt_out} !== {exp_busy, exp_done, exp_err, exp_cnt}) begin
                tests_failed++;
                $display("FAIL status t=%0t got busy%b done%b err%b cnt%0d exp busy%b done%b err%b cnt%0d",
                         $time, busy_out, done_out, err_out, frame_cnt_out,
                         exp_busy, exp_done, exp_err, exp_cnt);
            end
            if (mem_we_out === 1'b1) begin writes_seen++; last_waddr = mem_addr_out; end
            if (rd_grant_out === 1'b1) grants_seen++;
            if (done_out === 1'b1) done_seen++;
        end
    end

    task automatic do_reset();
        mon_en = 0;
        @(posedge clk_in); #1;
        rst_in = 0;
        start_in = 0; abort_in = 0; continuous_in = 0; pix_valid_in = 0;
        hcount_in = '0; vcount_in = '0; rd_req_in = 0; rd_addr_in = '0;
        model_reset();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1;
        @(posedge clk_in); #1;
        mon_en = 1;
    endtask

    task automatic test_reset();
        mon_en = 0;
        rst_in = 0;
        rd_req_in = 1; rd_addr_in = 17'd77; pix_valid_in = 1;
        #3;
        tests_run++;
        if ({thr_valid_out, rd_grant_out, rd_valid_out, mem_we_out, busy_out, done_out,
             err_out, mem_addr_out, frame_cnt_out, state_dbg_out} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs grant%b we%b busy%b addr%0d cnt%0d exp all zero",
                     rd_grant_out, mem_we_out, busy_out, mem_addr_out, frame_cnt_out);
        end
        do_reset();
        tests_run++;
        if ({busy_out, done_out, err_out, mem_we_out, frame_cnt_out} !== '0) begin
            tests_failed++;
            $display("FAIL reset_release busy%b done%b err%b we%b cnt%0d exp zeros",
                     busy_out, done_out, err_out, mem_we_out, frame_cnt_out);
        end
    endtask

    task automatic test_clean_frame();
        int w0, d0;
        w0 = writes_seen; d0 = done_seen;
        step(1'b0, 9'd0, 8'd0, 1'b1, 1'b0);
        for (int v = 0; v < V; v++) begin
            for (int h = 0; h < H; h++) begin
                step(1'b1, 9'(h), 8'(v), 1'b0, 1'b0);
                if (v == 0 && h == 0) begin
                    tests_run++;
                    if (mem_we_out !== 1'b1 || mem_addr_out !== 17'd0) begin tests_failed++;
                        $display("FAIL clean_first_write we=%b addr=%0d exp we=1 addr=0", mem_we_out, mem_addr_out); end
                end
            end
        end
        idle(3);
        tests_run++;
        if (writes_seen - w0 !== 76800) begin tests_failed++;
            $display("FAIL clean_write_count got %0d exp 76800", writes_seen - w0); end
        tests_run++;
        if (last_waddr !== 17'd76799) begin tests_failed++;
            $display("FAIL clean_last_addr got %0d exp 76799", last_waddr); end
        tests_run++;
        if (done_seen - d0 !== 1) begin tests_failed++;
            $display("FAIL clean_done_pulses got %0d exp 1", done_seen - d0); end
        tests_run++;
        if (frame_cnt_out !== 8'd1 || busy_out !== 1'b0) begin tests_failed++;
            $display("FAIL clean_end cnt=%0d busy=%b exp cnt=1 busy=0", frame_cnt_out, busy_out); end
    endtask

    task automatic test_out_of_range();
        int w0;
        step(1'b0, 9'd0, 8'd0, 1'b1, 1'b0);
        step(1'b1, 9'd0, 8'd0, 1'b0, 1'b0);
        w0 = writes_seen;
        for (int h = 320; h < 400; h++) step(1'b1, 9'(h), 8'd5, 1'b0, 1'b0);
        step(1'b1, 9'd10, 8'd5, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++)
            step(1'b1, 9'($urandom_range(0, 511)), 8'($urandom_range(240, 255)), 1'b0, 1'b0);
        idle(2);
        tests_run++;
        if (writes_seen - w0 !== 2) begin tests_failed++;
            $display("FAIL oor_write_count got %0d exp 2", writes_seen - w0); end
        step(1'b0, 9'd0, 8'd0, 1'b0, 1'b1);
        tests_run++;
        if (busy_out !== 1'b0) begin tests_failed++;
            $display("FAIL oor_abort_busy got %b exp 0", busy_out); end
    endtask

    task automatic test_restart_err();
        step(1'b0, 9'd0, 8'd0, 1'b1, 1'b0);
        step(1'b1, 9'd0, 8'd0, 1'b0, 1'b0);
        for (int r = 1; r < 100; r += 9)
            step(1'b1, 9'($urandom_range(0, 319)), 8'(r), 1'b0, 1'b0);
        step(1'b1, 9'd7, 8'd100, 1'b0, 1'b0);
        step(1'b1, 9'd0, 8'd0, 1'b0, 1'b0);
        tests_run++;
        if (err_out !== 1'b1 || busy_out !== 1'b1) begin tests_failed++;
            $display("FAIL restart_err err=%b busy=%b exp err=1 busy=1", err_out, busy_out); end
        tests_run++;
        if (mem_we_out !== 1'b1 || mem_addr_out !== 17'd0) begin tests_failed++;
            $display("FAIL restart_addr we=%b addr=%0d exp we=1 addr=0", mem_we_out, mem_addr_out); end
        step(1'b1, 9'd1, 8'd0, 1'b0, 1'b0);
        step(1'b0, 9'd0, 8'd0, 1'b0, 1'b1);
        idle(2);
        tests_run++;
        if (err_out !== 1'b1) begin tests_failed++;
            $display("FAIL err_sticky got %b exp 1", err_out); end
        step(1'b0, 9'd0, 8'd0, 1'b1, 1'b0);
        tests_run++;
        if (err_out !== 1'b0 || busy_out !== 1'b1) begin tests_failed++;
            $display("FAIL err_clear err=%b busy=%b exp err=0 busy=1", err_out, busy_out); end
        step(1'b0, 9'd0, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic test_continuous();
        int d0;
        do_reset();
        d0 = done_seen;
        cont_v = 1;
        step(1'b0, 9'd0, 8'd0, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++) begin
            step(1'b1, 9'd0, 8'd0, 1'b0, 1'b0);
            repeat ($urandom_range(20, 40)) begin
                case ($urandom_range(0, 3))
                    0: step(1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
                    1: step(1'b1, 9'($urandom_range(320, 511)), 8'($urandom_range(0, 255)), 1'b0, 1'b0);
                    default: step(1'b1, 9'($urandom_range(0, 319)), 8'($urandom_range(1, 238)), 1'b0, 1'b0);
                endcase
            end
            if (f == 2) cont_v = 0;
            step(1'b1, 9'd319, 8'd239, 1'b0, 1'b0);
            step(1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
        end
        idle(2);
        tests_run++;
        if (done_seen - d0 !== 3) begin tests_failed++;
            $display("FAIL cont_done_pulses got %0d exp 3", done_seen - d0); end
        tests_run++;
        if (frame_cnt_out !== 8'd3 || busy_out !== 1'b0) begin tests_failed++;
            $display("FAIL cont_end cnt=%0d busy=%b exp cnt=3 busy=0", frame_cnt_out, busy_out); end
    endtask

    task automatic test_read_arb();
        int g0;
        step(1'b0, 9'd0, 8'd0, 1'b1, 1'b0);
        step(1'b1, 9'd0, 8'd0, 1'b0, 1'b0);
        rd_pend = 1; rd_addr_v = 17'd500;
        g0 = grants_seen;
        for (int h = 1; h <= 10; h++) step(1'b1, 9'(h), 8'd0, 1'b0, 1'b0);
        step(1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
        tests_run++;
        if (grants_seen - g0 !== 0) begin tests_failed++;
            $display("FAIL rd_during_burst grants=%0d exp 0", grants_seen - g0); end
        step(1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
        tests_run++;
        if (grants_seen - g0 !== 1 || rd_valid_out !== 1'b0) begin tests_failed++;
            $display("FAIL rd_first_gap grants=%0d rd_valid=%b exp 1 and 0", grants_seen - g0, rd_valid_out); end
        step(1'b0, 9'd0, 8'd0, 1'b0, 1'b0);
        tests_run++;
        if (rd_valid_out !== 1'b1) begin tests_failed++;
            $display("FAIL rd_valid_lat got %b exp 1", rd_valid_out); end
        step(1'b0, 9'd0, 8'd0, 1'b0, 1'b1);
        idle(2);
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_seen;
        step(1'b0, 9'd0, 8'd0, 1'b1, 1'b0);
        step(1'b1, 9'd0, 8'd0, 1'b0, 1'b0);
        step(1'b1, 9'd1, 8'd0, 1'b0, 1'b0);
        step(1'b1, 9'd2, 8'd0, 1'b0, 1'b0);
        step(1'b1, 9'd3, 8'd0, 1'b0, 1'b1);
        tests_run++;
        if (busy_out !== 1'b0 || mem_we_out !== 1'b0) begin tests_failed++;
            $display("FAIL abort_idle busy=%b we=%b exp 0 0", busy_out, mem_we_out); end
        for (int h = 4; h < 10; h++) step(1'b1, 9'(h), 8'd0, 1'b0, 1'b0);
        tests_run++;
        if (done_seen - d0 !== 0) begin tests_failed++;
            $display("FAIL abort_no_done got %0d exp 0", done_seen - d0); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            logic st, ab, pv;
            logic [8:0] h;
            logic [7:0] v;
            int r;
            st = ($urandom_range(0, 19) == 0);
            ab = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) cont_v = ~cont_v;
            if (!rd_pend && $urandom_range(0, 3) == 0) begin
                rd_pend = 1; rd_addr_v = 17'($urandom_range(0, 76799));
            end
            r = $urandom_range(0, 99);
            pv = 1; h = 9'($urandom_range(0, 319)); v = 8'($urandom_range(0, 239));
            if (r < 30) pv = 0;
            else if (r < 40) h = 9'($urandom_range(320, 511));
            else if (r < 45) begin h = 0; v = 0; end
            else if (r < 50) begin h = 9'd319; v = 8'd239; end
            step(pv, h, v, st, ab);
        end
        step(1'b0, 9'd0, 8'd0, 1'b0, 1'b1);
        tests_run++;
        if (busy_out !== 1'b0) begin tests_failed++;
            $display("FAIL random_abort_busy got %b exp 0", busy_out); end
        idle(3);
    endtask

    task automatic test_async_reset();
        step(1'b0, 9'd0, 8'd0, 1'b1, 1'b0);
        step(1'b1, 9'd0, 8'd0, 1'b0, 1'b0);
        step(1'b1, 9'd1, 8'd0, 1'b0, 1'b0);
        tests_run++;
        if (busy_out !== 1'b1 || mem_we_out !== 1'b1) begin tests_failed++;
            $display("FAIL async_pre busy=%b we=%b exp 1 1", busy_out, mem_we_out); end
        mon_en = 0;
        pix_valid_in = 1; hcount_in = 9'd2; vcount_in = 8'd0;
        rd_req_in = 1; rd_addr_in = 17'd1234;
        #2;
        rst_in = 0;
        #1;
        tests_run++;
        if ({thr_valid_out, rd_grant_out, rd_valid_out, mem_we_out, busy_out, done_out,
             err_out, mem_addr_out, frame_cnt_out} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset thr%b grant%b we%b busy%b err%b addr%0d cnt%0d exp all zero",
                     thr_valid_out, rd_grant_out, mem_we_out, busy_out, err_out, mem_addr_out, frame_cnt_out);
        end
        do_reset();
    endtask

    initial begin
        #5_000_000;
        tests_failed++;
        $display("FAIL watchdog simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rd_addr_v = '0;
        test_reset();
        test_clean_frame();
        test_out_of_range();
        test_restart_err();
        test_read_arb();
        test_abort();
        test_random();
        test_continuous();
        test_async_reset();
        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Sequences the capture of one 320x240 camera frame through the threshold stage into a single-port frame-buffer BRAM.
- Gates the pixel stream into the threshold stage and generates delay-matched BRAM write addresses and enables.
- Arbitrates the same BRAM port between capture writes and a downstream reader. Writes always win.
- Sits between the camera pixel stream and the frame buffer; threshold output data goes straight to BRAM din.

Parameters:
- H_ACTIVE, 320, pixels per line.
- V_ACTIVE, 240, lines per frame.
- TH_LAT, 1, threshold stage latency in cycles (valid to valid_out).
- RD_LAT, 2, BRAM read latency in cycles.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- start_in  input  1  one-cycle request to arm a capture.
- continuous_in  input  1  sampled at DONE: 1 re-arms automatically.
- abort_in  input  1  return to IDLE immediately.
- hcount_in  input  9  column of incoming pixel.
- vcount_in  input  8  row of incoming pixel.
- pix_valid_in  input  1  incoming pixel valid.
- thr_valid_out  output  1  valid to threshold stage.
- rd_req_in  input  1  reader request, level; held until granted.
- rd_addr_in  input  17  reader address.
- rd_grant_out  output  1  read issued this cycle.
- rd_valid_out  output  1  BRAM dout valid for the granted read.
- mem_addr_out  output  17  BRAM address.
- mem_we_out  output  1  BRAM write enable.
- busy_out  output  1  state is ARMED or CAPTURE.
- done_out  output  1  one-cycle pulse, frame complete.
- err_out  output  1  sticky short-frame error; cleared by start_in.
- frame_cnt_out  output  8  completed frames, wraps 255 to 0.

Behaviour:
- Reset (rst_in=0, async): state IDLE; all outputs 0; pipelines cleared.
- In-range pixel: pix_valid_in=1, hcount_in<H_ACTIVE, vcount_in<V_ACTIVE. Out-of-range pixels are never forwarded.
- Frame-start pixel: in-range pixel with hcount_in=0 and vcount_in=0.

States:
- IDLE: start_in goes to ARMED and clears err_out.
- ARMED: a frame-start pixel goes to CAPTURE, and that pixel is forwarded.
- CAPTURE:
  - Forward every in-range pixel: thr_valid_out = pix_valid_in combinationally, same cycle.
  - Pixel (H_ACTIVE-1, V_ACTIVE-1) forwarded goes to DONE.
  - A frame-start pixel arriving before the end sets err_out, stays in CAPTURE and restarts at address 0. This pixel is forwarded.
- DONE: lasts 1 cycle. done_out=1 and frame_cnt_out increments. Next state is ARMED if continuous_in=1, else IDLE.
- abort_in (any state, highest priority after reset) goes to IDLE next cycle. Pixels already in the pipeline still complete their writes.
- start_in outside IDLE is ignored.

Write path:
- Address = vcount_in*H_ACTIVE + hcount_in, computed at forward time.
- Address and valid are delayed TH_LAT registers. mem_we_out equals the delayed valid, aligned with threshold data_valid_out.

Arbitration:
- Write cycle: mem_addr_out = delayed write address, mem_we_out=1, rd_grant_out=0.
- Otherwise, if rd_req_in=1: mem_addr_out = rd_addr_in, rd_grant_out=1 (combinational), mem_we_out=0.
- rd_valid_out = rd_grant_out delayed RD_LAT cycles.
- No read is starved within a frame; blanking gaps supply read slots.

Width rules:
- Address max 76799, fits 17 bits.
- frame_cnt_out is modulo 256.

Test Plan:
- Reset then start_in and one clean frame (TH_LAT=1) -> first mem_we_out one cycle after pixel (0,0) with addr 0; last write addr 76799; done_out pulses once; frame_cnt_out=1; state returns to IDLE; exactly 76800 writes.
- Pixels with hcount_in=320..399 and vcount_in=240 during CAPTURE -> no thr_valid_out and no mem_we_out for them.
- Frame restarts at (0,0) after row 100 -> err_out=1 and the next write address is 0. A subsequent start_in in IDLE clears err_out.
- continuous_in=1 over 3 frames -> done_out pulses 3 times; frame_cnt_out=3; ARMED between frames with no idle gap in forwarding.
- rd_req_in held, addr 500, during a write burst -> no grant while mem_we_out=1. On the first gap cycle: rd_grant_out=1, mem_addr_out=500, and rd_valid_out=1 exactly 2 cycles later.
- Mid-frame: abort_in -> IDLE next cycle, busy_out=0, the pipelined write completes, no done_out. Separately, mid-frame async rst_in=0 -> all outputs 0 immediately.
